// File: rtl/cdb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_pkg
//  Description : Shared types and defaults for the common-data-bus arbiter.
//                cdb_lane_t describes one broadcast lane (valid, tag, data)
//                at the default widths; ptr_width() sizes the round-robin
//                pointer so that a single requester still gets one bit.
//  Revision    : 1.0 - initial release
// ============================================================================
package cdb_pkg;

    localparam int C_TAG_W   = 4;
    localparam int C_DATA_W  = 32;
    localparam int C_NUM_CDB = 2;

    typedef struct packed {
        logic                wr;
        logic [C_TAG_W-1:0]  tag;
        logic [C_DATA_W-1:0] wdata;
    } cdb_lane_t;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Rotated find-first-set. Scans vec starting at index start,
//                wrapping from N-1 back to 0, and returns the first set bit.
//  Ports       : vec   - candidate vector
//                start - scan start index (must be < N)
//                grant - one-hot position of the first set bit found
//                found - high when any bit of vec is set
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  vec,
    input  logic [PW-1:0] start,
    output logic [N-1:0]  grant,
    output logic          found
);

    // One extra bit so start+offset (< 2N) never overflows before the wrap.
    logic [PW:0] w_idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        w_idx = '0;
        for (int off = 0; off < N; off++) begin
            w_idx = {1'b0, start} + (PW+1)'(off);
            if (w_idx >= (PW+1)'(N)) begin
                w_idx = w_idx - (PW+1)'(N);
            end
            if (!found && vec[w_idx[PW-1:0]]) begin
                grant[w_idx[PW-1:0]] = 1'b1;
                found                = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cdb_arb.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arb
//  Description : Common-data-bus arbiter. Grants up to NUM_CDB of NUM_REQ
//                execution-unit requesters per cycle in rotated round-robin
//                order (optional fixed priority for requester 0 on lane 0)
//                and broadcasts the granted tag/data one cycle later.
//  Ports       : clk, rst_n (async, active-low), flush (squash grants)
//                req/rdy      - per-requester request / grant handshake
//                tag/wdata    - per-requester result, packed requester-major
//                cdb_wr/cdb_tag/cdb_wdata - per-lane registered broadcast
//  Revision    : 1.0 - initial release
// ============================================================================
module cdb_arb
    import cdb_pkg::*;
#(
    parameter int TAG_W   = C_TAG_W,
    parameter int DATA_W  = C_DATA_W,
    parameter int NUM_REQ = 4,
    parameter int NUM_CDB = C_NUM_CDB,
    parameter int PRIO_EN = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic [NUM_REQ-1:0]          req,
    output logic [NUM_REQ-1:0]          rdy,
    input  logic [NUM_REQ*TAG_W-1:0]    tag,
    input  logic [NUM_REQ*DATA_W-1:0]   wdata,
    output logic [NUM_CDB-1:0]          cdb_wr,
    output logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
    output logic [NUM_CDB*DATA_W-1:0]   cdb_wdata
);

    localparam int PW = ptr_width(NUM_REQ);

    if (NUM_CDB < 1 || NUM_CDB > NUM_REQ) begin : g_cfg_check
        $error("cdb_arb: NUM_CDB must satisfy 1 <= NUM_CDB <= NUM_REQ");
    end

    logic [PW-1:0]              r_rr_ptr;
    logic [PW-1:0]              w_rr_next;
    logic                       w_prio;
    logic [NUM_REQ-1:0]         w_vec0;
    logic [NUM_CDB-1:0]         w_lane_rr;
    logic [NUM_CDB-1:0][PW-1:0] w_gnt_idx;

    assign w_prio = (PRIO_EN != 0) && req[0] && !flush;
    assign w_vec0 = flush ? '0 : req;

    for (genvar k = 0; k < NUM_CDB; k++) begin : g_lane
        logic [NUM_REQ-1:0] w_vec;
        logic [NUM_REQ-1:0] w_pick;
        logic [NUM_REQ-1:0] w_gnt;
        logic [NUM_REQ-1:0] w_next;
        logic               w_found;
        logic               w_lane_gnt;
        logic [PW-1:0]      w_idx;
        logic [TAG_W-1:0]   w_tag;
        logic [DATA_W-1:0]  w_wdata;
        logic               r_wr;
        logic [TAG_W-1:0]   r_tag;
        logic [DATA_W-1:0]  r_wdata;

        // Each lane only sees requesters not already taken by earlier lanes,
        // so lane k ends up with the k-th requester in scan order.
        if (k == 0) begin : g_first
            assign w_vec = w_vec0;
        end else begin : g_chain
            assign w_vec = g_lane[k-1].w_next;
        end

        rr_pick #(
            .N  (NUM_REQ),
            .PW (PW)
        ) u_pick (
            .vec   (w_vec),
            .start (r_rr_ptr),
            .grant (w_pick),
            .found (w_found)
        );

        // A fixed-priority grant on lane 0 overrides the scan and is not a
        // round-robin grant, so it never moves the pointer.
        if (k == 0) begin : g_prio_lane
            assign w_gnt        = w_prio ? NUM_REQ'(1) : w_pick;
            assign w_lane_gnt   = w_prio | w_found;
            assign w_lane_rr[k] = !w_prio && w_found;
        end else begin : g_rr_lane
            assign w_gnt        = w_pick;
            assign w_lane_gnt   = w_found;
            assign w_lane_rr[k] = w_found;
        end

        assign w_next       = w_vec & ~w_gnt;
        assign w_gnt_idx[k] = w_idx;

        // One-hot grant to index and data mux; grant is one-hot or zero.
        always_comb begin
            w_idx   = '0;
            w_tag   = '0;
            w_wdata = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_gnt[i]) begin
                    w_idx   = PW'(i);
                    w_tag   = tag[i*TAG_W +: TAG_W];
                    w_wdata = wdata[i*DATA_W +: DATA_W];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_wr    <= 1'b0;
                r_tag   <= '0;
                r_wdata <= '0;
            end else begin
                r_wr <= w_lane_gnt;
                if (w_lane_gnt) begin
                    r_tag   <= w_tag;
                    r_wdata <= w_wdata;
                end
            end
        end

        assign cdb_wr[k]                      = r_wr;
        assign cdb_tag[k*TAG_W +: TAG_W]      = r_tag;
        assign cdb_wdata[k*DATA_W +: DATA_W]  = r_wdata;
    end

    // Every bit removed across the lane chain was granted.
    assign rdy = w_vec0 & ~g_lane[NUM_CDB-1].w_next;

    // Pointer follows the last round-robin grant; lanes are in scan order,
    // so the highest granting lane wins.
    always_comb begin
        w_rr_next = r_rr_ptr;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (w_lane_rr[k]) begin
                w_rr_next = (w_gnt_idx[k] == PW'(NUM_REQ-1)) ? '0
                                                             : w_gnt_idx[k] + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else begin
            r_rr_ptr <= w_rr_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdb_arb
//  Description : Scoreboard bench for cdb_arb. Two instances (round-robin
//                only, and fixed priority for requester 0) share stimulus.
//                A reference model predicts grants, rdy and the round-robin
//                pointer each cycle and queues the expected broadcast; a
//                monitor pops and compares the lanes one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arb;
    import cdb_pkg::*;

    localparam int NREQ = 4;
    localparam int NCDB = 2;
    localparam int TW   = 4;
    localparam int DW   = 32;

    typedef cdb_lane_t [NCDB-1:0] lanes_t;

    logic                  clk;
    logic                  rst_n;
    logic                  flush;
    logic [NREQ-1:0]       req;
    logic [NREQ*TW-1:0]    tag;
    logic [NREQ*DW-1:0]    wdata;

    logic [1:0][NREQ-1:0]    rdy_o;
    logic [1:0][NCDB-1:0]    wr_o;
    logic [1:0][NCDB*TW-1:0] tag_o;
    logic [1:0][NCDB*DW-1:0] data_o;

    int errors;
    int checks;

    lanes_t q0[$];
    lanes_t q1[$];

    cdb_arb #(.TAG_W(TW), .DATA_W(DW), .NUM_REQ(NREQ), .NUM_CDB(NCDB), .PRIO_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .req(req), .rdy(rdy_o[0]),
        .tag(tag), .wdata(wdata), .cdb_wr(wr_o[0]), .cdb_tag(tag_o[0]), .cdb_wdata(data_o[0])
    );

    cdb_arb #(.TAG_W(TW), .DATA_W(DW), .NUM_REQ(NREQ), .NUM_CDB(NCDB), .PRIO_EN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .req(req), .rdy(rdy_o[1]),
        .tag(tag), .wdata(wdata), .cdb_wr(wr_o[1]), .cdb_tag(tag_o[1]), .cdb_wdata(data_o[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Grant rules stated directly: optional fixed grant of requester 0, then
    // scan from ptr with wrap, taking the first free requesters.
    function automatic void model_grant(input logic [NREQ-1:0] r, input logic fl,
                                        input int ptr, input bit prio,
                                        output int lr[NCDB], output int nl, output int np);
        bit fixed;
        nl = 0;
        np = ptr;
        for (int k = 0; k < NCDB; k++) lr[k] = 0;
        if (fl) return;
        fixed = prio && r[0];
        if (fixed) begin
            lr[0] = 0;
            nl    = 1;
        end
        for (int off = 0; off < NREQ; off++) begin
            int i;
            i = (ptr + off) % NREQ;
            if (nl < NCDB && r[i] && !(fixed && i == 0)) begin
                lr[nl] = i;
                nl++;
                np = (i + 1) % NREQ;
            end
        end
    endfunction

    // Reference model: runs mid-cycle, checks rdy and pointer, queues the
    // broadcast expected after the next rising edge.
    initial begin
        int mptr[2];
        mptr[0] = 0;
        mptr[1] = 0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                int        lr[NCDB];
                int        nl;
                int        np;
                lanes_t    e;
                logic [NREQ-1:0] erdy;
                logic [1:0]      dptr;
                if (!rst_n) mptr[d] = 0;
                model_grant(req, flush, mptr[d], d == 1, lr, nl, np);
                erdy = '0;
                e    = '0;
                for (int k = 0; k < nl; k++) begin
                    erdy[lr[k]]  = 1'b1;
                    e[k].wr      = 1'b1;
                    e[k].tag     = tag[lr[k]*TW +: TW];
                    e[k].wdata   = wdata[lr[k]*DW +: DW];
                end
                checks++;
                if (rdy_o[d] !== erdy) begin
                    errors++;
                    $display("FAIL rdy dut%0d t=%0t: got %b expected %b", d, $time, rdy_o[d], erdy);
                end
                dptr = (d == 0) ? dut0.r_rr_ptr : dut1.r_rr_ptr;
                checks++;
                if (dptr !== 2'(mptr[d])) begin
                    errors++;
                    $display("FAIL rr_ptr dut%0d t=%0t: got %0d expected %0d", d, $time, dptr, mptr[d]);
                end
                if (rst_n) mptr[d] = np;
                else       e = '0;
                if (d == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end
    end

    // Monitor: compares the registered broadcast shortly after each edge.
    initial begin
        @(negedge clk);
        forever begin
            @(posedge clk);
            #2;
            for (int d = 0; d < 2; d++) begin
                lanes_t e;
                bit     empty;
                empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
                checks++;
                if (empty) begin
                    errors++;
                    $display("FAIL scoreboard dut%0d t=%0t: got empty queue expected an entry", d, $time);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    // Reset drops lanes at once, whatever was in flight.
                    if (!rst_n) e = '0;
                    for (int k = 0; k < NCDB; k++) begin
                        logic          awr;
                        logic [TW-1:0] atag;
                        logic [DW-1:0] adat;
                        awr  = wr_o[d][k];
                        atag = tag_o[d][k*TW +: TW];
                        adat = data_o[d][k*DW +: DW];
                        checks++;
                        if (awr !== e[k].wr) begin
                            errors++;
                            $display("FAIL cdb_wr dut%0d lane%0d t=%0t: got %b expected %b", d, k, $time, awr, e[k].wr);
                        end
                        if (e[k].wr || !rst_n) begin
                            checks++;
                            if (atag !== e[k].tag || adat !== e[k].wdata) begin
                                errors++;
                                $display("FAIL cdb_payload dut%0d lane%0d t=%0t: got %h/%h expected %h/%h",
                                         d, k, $time, atag, adat, e[k].tag, e[k].wdata);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic step(input logic [NREQ-1:0] r, input logic fl, input logic rn);
        @(posedge clk);
        #1;
        req   = r;
        flush = fl;
        rst_n = rn;
        tag   = 16'($urandom);
        wdata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        flush  = 1'b0;
        req    = 4'b1111;
        tag    = 16'h3210;
        wdata  = {$urandom, $urandom, $urandom, $urandom};

        // Reset held with all requesting, then release.
        repeat (3) step(4'b1111, 1'b0, 1'b0);
        // Fairness, and priority instance reaches pointer 2 with all requesting.
        repeat (5) step(4'b1111, 1'b0, 1'b1);
        // Pointer to 3 in round-robin instance, then wrap case.
        step(4'b0100, 1'b0, 1'b1);
        step(4'b1001, 1'b0, 1'b1);
        // Flush squashes grants and holds the pointer.
        repeat (2) step(4'b0110, 1'b1, 1'b1);
        step(4'b0110, 1'b0, 1'b1);
        // Latency/data with a known payload, then idle.
        @(posedge clk);
        #1;
        req   = 4'b0100;
        flush = 1'b0;
        tag   = 16'h0A00;
        wdata = {32'h0, 32'hDEADBEEF, 32'h0, 32'h0};
        repeat (2) step(4'b0000, 1'b0, 1'b1);
        // Reset during traffic.
        step(4'b1111, 1'b0, 1'b1);
        step(4'($urandom), 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b1);
        // Random traffic with occasional flush and reset.
        for (int n = 0; n < 400; n++) begin
            step(4'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) != 0));
        end
        repeat (3) step(4'b0000, 1'b0, 1'b1);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
